mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM register. It consumes the registered address, store data, destination register, control byte and opcode. It performs word (optionally byte) loads and stores against an internal data RAM with a fixed multi-cycle access latency, stalling upstream while busy. Results are registered into the MEM/WB outputs that feed write-back.

## Interface
- DEPTH, 256: data RAM words; index is mem_addr[log2(DEPTH)+1:2], upper bits ignored (wrap).
- MEM_LAT, 2: access latency in cycles, legal range 1..15.
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mem_addr  in  32  ALU result; memory address for loads/stores, pass-through value otherwise.
- data_in  in  32  store data.
- rd_mem  in  5  destination register.
- control_MEM  in  8  bit0 mem_read, bit1 mem_write, bit2 reg_write, bit3 mem_to_reg, bit4 byte access, bits7:5 passed through.
- opcode_wb  in  6  opcode travelling with the instruction.
- mem_stall  out  1  combinational; upstream must hold all inputs stable while high.
- wb_data  out  32  registered load data or mem_addr pass-through.
- rd_wb  out  5  registered destination register.
- control_WB  out  8  registered control byte.
- opcode_out  out  6  registered opcode.

## Operation
- Access = control_MEM[0] | control_MEM[1]. If both bits are set, the access is a write only; bit0 is ignored.
- FSM states: IDLE, BUSY. Down-counter cnt is 4 bits wide.
- IDLE, no access: at the edge, MEM/WB loads {wb_data=mem_addr, rd_mem, control_MEM, opcode_wb}. Stay in IDLE.
- IDLE, access: at the edge, go to BUSY with cnt=MEM_LAT-1. MEM/WB loads a bubble (all zeros).
- BUSY, cnt!=0: decrement cnt. MEM/WB loads a bubble.
- BUSY, cnt==0: complete the access at the edge and return to IDLE.
  - Write: the RAM is written.
  - Read: wb_data = RAM word (or byte, see Configuration).
  - Write: wb_data = mem_addr.
  - rd_wb, control_WB and opcode_out are taken from the held inputs.
- mem_stall = !reset & ((IDLE & access) | (BUSY & cnt!=0)). It is low in the completion cycle, so upstream advances on the same edge the result registers.
- Each instruction appears on the MEM/WB outputs exactly once, with non-zero control. Bubbles carry control_WB=0, so reg_write=0.
- RAM: synchronous write, asynchronous read. Contents are not cleared by reset.

## Timing
- Non-memory op: result on outputs 1 edge after presentation.
- Memory op: result on outputs MEM_LAT+1 edges after presentation. mem_stall is high for MEM_LAT cycles.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle following completion. Throughput is one access per MEM_LAT+1 cycles.
- Reset value of every output register is 0. State resets to IDLE and cnt to 0.
- Reset mid-access: the pending access is abandoned and no RAM write occurs. mem_stall is 0 during the reset cycle.
- A write followed by a read of the same address returns the new data, since the write commits before the read's completion edge.

## Configuration
- MEM_BYTE_EN defined: when control_MEM[4]=1, the lane is selected by mem_addr[1:0] (lane 0 = bits 7:0).
  - Stores write data_in[7:0] into the selected lane only.
  - Loads return that lane sign-extended to 32 bits.
- MEM_BYTE_EN undefined: control_MEM[4] is ignored and passed through unchanged. All accesses are full-word, and mem_addr[1:0] is ignored.

## Structure
- Package mem_stage_pkg contains:
  - control bit indices (CTL_MEM_READ=0, CTL_MEM_WRITE=1, CTL_REG_WRITE=2, CTL_MEM_TO_REG=3, CTL_BYTE=4);
  - FSM state encoding;
  - the default MEM_LAT.
- One sub-module: data_ram (DEPTH words, 4 byte-write enables, async read). The FSM and MEM/WB register stay in mem_stage.

## Test plan
- Reset: assert reset 2 cycles with an access in flight -> all outputs 0, mem_stall 0, no RAM change afterward.
- Pass-through: mem_addr=0x0000_1234, rd_mem=7, control_MEM=0x04 -> next edge wb_data=0x1234, rd_wb=7, control_WB=0x04, mem_stall never high.
- Store then load, MEM_LAT=2:
  - Store 0xDEAD_BEEF to 0x40: mem_stall high 2 cycles, RAM[16]=0xDEAD_BEEF after the completion edge.
  - Load 0x40 with control 0x0D: wb_data=0xDEAD_BEEF 3 edges after presentation.
  - Bubbles in between carry control_WB=0.
- Address wrap, DEPTH=256: store 0x11 to 0x400 -> RAM[0]=0x11, then load 0x0 returns 0x11.
- MEM_BYTE_EN, RAM[0]=0x1234_5678:
  - Byte store 0xFF to 0x2 -> RAM[0]=0x12FF_5678.
  - Byte load 0x2 -> wb_data=0xFFFF_FFFF.
  - Byte load 0x0 -> 0x0000_0078.
- Both read and write set (control 0x03): treated as a write, wb_data=mem_addr, RAM updated.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: control-byte bit
// positions, FSM state encoding, default access latency and byte-lane helpers.
package mem_stage_pkg;

  localparam int CTL_MEM_READ   = 0;
  localparam int CTL_MEM_WRITE  = 1;
  localparam int CTL_REG_WRITE  = 2;
  localparam int CTL_MEM_TO_REG = 3;
  localparam int CTL_BYTE       = 4;

  localparam int MEM_LAT_DEFAULT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] sext_byte(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_stage_data.sv
// Data RAM for the memory stage: DEPTH 32-bit words, per-byte synchronous
// write enables, asynchronous read. Contents are never reset.
module data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: multi-cycle loads/stores against data_ram, upstream stall,
// MEM/WB output register. Optional byte access enabled by defining MEM_BYTE_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] data_in,
  input  logic [4:0]  rd_mem,
  input  logic [7:0]  control_MEM,
  input  logic [5:0]  opcode_wb,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_wb,
  output logic [7:0]  control_WB,
  output logic [5:0]  opcode_out
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic [7:0]  control_wb_q, control_wb_d;
  logic [5:0]  opcode_q, opcode_d;

  logic          access, is_write;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be, ram_we;
  logic [31:0]   ram_wdata, ram_rdata, load_data;

  // A set write bit overrides the read bit.
  assign is_write = control_MEM[CTL_MEM_WRITE];
  assign access   = control_MEM[CTL_MEM_READ] | is_write;
  assign ram_addr = mem_addr[AW+1:2];

  data_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    ram_be    = 4'hF;
    ram_wdata = data_in;
    load_data = ram_rdata;
`ifdef MEM_BYTE_EN
    if (control_MEM[CTL_BYTE]) begin
      ram_be    = 4'b0001 << mem_addr[1:0];
      ram_wdata = {4{data_in[7:0]}};
      load_data = sext_byte(lane_byte(ram_rdata, mem_addr[1:0]));
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_stall    = 1'b0;
    ram_we       = 4'h0;
    wb_data_d    = '0;
    rd_wb_d      = '0;
    control_wb_d = '0;
    opcode_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          state_d   = ST_BUSY;
          cnt_d     = CNT_INIT;
          mem_stall = 1'b1;
        end else begin
          wb_data_d    = mem_addr;
          rd_wb_d      = rd_mem;
          control_wb_d = control_MEM;
          opcode_d     = opcode_wb;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d     = cnt_q - 4'd1;
          mem_stall = 1'b1;
        end else begin
          // Completion edge: inputs are still held, so commit and register the result.
          state_d      = ST_IDLE;
          ram_we       = is_write ? ram_be : 4'h0;
          wb_data_d    = is_write ? mem_addr : load_data;
          rd_wb_d      = rd_mem;
          control_wb_d = control_MEM;
          opcode_d     = opcode_wb;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset abandons any pending access and must not disturb the RAM.
    if (reset) begin
      mem_stall = 1'b0;
      ram_we    = 4'h0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wb_data_q    <= '0;
      rd_wb_q      <= '0;
      control_wb_q <= '0;
      opcode_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_data_q    <= wb_data_d;
      rd_wb_q      <= rd_wb_d;
      control_wb_q <= control_wb_d;
      opcode_q     <= opcode_d;
    end
  end

  assign wb_data    = wb_data_q;
  assign rd_wb      = rd_wb_q;
  assign control_WB = control_wb_q;
  assign opcode_out = opcode_q;

endmodule
